// File: rtl/definitions_pkg.sv
// Shared UART definitions.
// Holds the baud divisor and oversample factor common to the transmitter and rx_top,
// the derived bit period in clk cycles, and the transmitter FSM state type.
package definitions_pkg;

    localparam int unsigned DIVISOR    = 2;
    localparam int unsigned OVERSAMPLE = 4;
    localparam int unsigned BIT_CYCLES = DIVISOR * OVERSAMPLE;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter.
// Counts 0..CYCLES-1 and wraps. tick_o is high on the final cycle of each period.
// restart_i reloads the count to 0 on the next edge, so a new period starts aligned
// with whatever event raised it.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset (count to 0)
//   restart_i synchronous restart of the period
//   tick_o    last cycle of the current period
module uart_baud_tick
    import definitions_pkg::*;
#(
    parameter int unsigned CYCLES = definitions_pkg::BIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned     CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CntW-1:0] Last = CntW'(CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter.
// Accepts bytes over a valid/ready handshake into a one-entry holding register and
// shifts them out LSB first as start / 8 data / [parity] / stop frames. A held byte is
// moved into the shifter on the last stop cycle, so back-to-back frames have no gap.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after the data.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   din       byte to transmit, taken when tx_start && tx_ready
//   tx_start  byte valid
//   tx_ready  holding register empty
//   tx        serial line, idles high, driven from a flop
//   tx_busy   a frame is on the line
//   tx_done   one-cycle pulse on the final stop cycle
module uart_tx
    import definitions_pkg::*;
#(
    parameter int unsigned DIVISOR    = definitions_pkg::DIVISOR,
    parameter int unsigned OVERSAMPLE = definitions_pkg::OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned BitCycles = DIVISOR * OVERSAMPLE;

    tx_state_t  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       tx_q, tx_d;
    logic       bit_end;
    logic       restart;
    logic       load;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    // Every state change starts a fresh bit period.
    assign restart = (state_d != state_q);

    uart_baud_tick #(
        .CYCLES (BitCycles)
    ) u_baud_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart),
        .tick_o    (bit_end)
    );

    // Held byte enters the shifter from IDLE or straight out of the last stop cycle.
    assign load = hold_valid_q && ((state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end));

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
`endif

        if (tx_start && !hold_valid_q) begin
            hold_d       = din;
            hold_valid_d = 1'b1;
        end

        if (load) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            bit_cnt_d    = 3'd0;
`ifdef UART_TX_PARITY_EN
            par_d        = ^hold_q;
`endif
            state_d      = TX_START;
        end else begin
            case (state_q)
                TX_IDLE: ;
                TX_START: begin
                    if (bit_end) state_d = TX_DATA;
                end
                TX_DATA: begin
                    if (bit_end) begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_d = TX_PARITY;
`else
                            state_d = TX_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (bit_end) state_d = TX_STOP;
                end
`endif
                TX_STOP: begin
                    if (bit_end) state_d = TX_IDLE;
                end
                default: state_d = TX_IDLE;
            endcase
        end

        // Line level follows the next state so tx changes on the same edge as the state.
        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= TX_IDLE;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = !hold_valid_q;
    assign tx_busy  = (state_q != TX_IDLE);
    assign tx_done  = (state_q == TX_STOP) && bit_end;

endmodule
